// File: rtl/ifm_buf_ctrl_if.sv
// Handshake/bus bundle between the IFM window-buffer sequencer and its neighbours
// (layer control, IFM memory, window buffer, PE array).
interface ifm_buf_ctrl_if #(
  parameter int DIM_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             fetch_en;
  logic [DIM_W-1:0] fetch_row;
  logic [DIM_W-1:0] fetch_col;
  logic [2:0]       ifm_read;
  logic             win_valid;
  logic             win_ready;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             win_last;

  modport master (
    input  start, win_ready,
    output busy, done, fetch_en, fetch_row, fetch_col, ifm_read,
           win_valid, win_row, win_col, win_last
  );

  modport slave (
    output start, win_ready,
    input  busy, done, fetch_en, fetch_row, fetch_col, ifm_read,
           win_valid, win_row, win_col, win_last
  );
endinterface

// File: rtl/ifm_buf_ctrl.sv
// Snake-order 3x3 window sequencer: fetch, then buffer command, then window; 3 cycles/window.
// Stalls in WIN while win_ready is low (buffer held by KEEP). IFM_CTRL_PERF_EN adds stall_cnt.
module ifm_buf_ctrl #(
  parameter int IFM_H = 8,
  parameter int IFM_W = 8,
  parameter int DIM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ifm_buf_ctrl_if.master       bus
`ifdef IFM_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam logic [2:0] ALL   = 3'b111;
  localparam logic [2:0] RIGHT = 3'b001;
  localparam logic [2:0] DOWN  = 3'b010;
  localparam logic [2:0] LEFT  = 3'b100;
  localparam logic [2:0] KEEP  = 3'b000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DIM_W-1:0] R_LAST = DIM_W'(IFM_H - 3);
  localparam logic [DIM_W-1:0] C_LAST = DIM_W'(IFM_W - 3);
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

  logic [2:0]       state;
  logic [DIM_W-1:0] r;
  logic [DIM_W-1:0] c;
  logic             dir_right;
  logic [2:0]       cmd;
  logic             last;
  logic             hs;

  // The last window sits at the end of the final row in whichever direction that row runs.
  assign last = (r == R_LAST) && (dir_right ? (c == C_LAST) : (c == '0));
  assign hs   = (state == S_WIN) && bus.win_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r         <= '0;
      c         <= '0;
      dir_right <= 1'b1;
      cmd       <= KEEP;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            r         <= '0;
            c         <= '0;
            dir_right <= 1'b1;
            cmd       <= ALL;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD:  state <= S_WIN;
        S_WIN: begin
          if (hs) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
              if (dir_right && (c < C_LAST)) begin
                cmd <= RIGHT;
                c   <= c + ONE;
              end else if (!dir_right && (c != '0)) begin
                cmd <= LEFT;
                c   <= c - ONE;
              end else begin
                cmd       <= DOWN;
                r         <= r + ONE;
                dir_right <= ~dir_right;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so a reset cancels any command on the same edge.
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.fetch_en  = (state == S_FETCH);
  assign bus.fetch_row = (state == S_FETCH) ? r : '0;
  assign bus.fetch_col = (state == S_FETCH) ? c : '0;
  assign bus.ifm_read  = (state == S_LOAD) ? cmd : KEEP;
  assign bus.win_valid = (state == S_WIN);
  assign bus.win_row   = (state == S_WIN) ? r : '0;
  assign bus.win_col   = (state == S_WIN) ? c : '0;
  assign bus.win_last  = (state == S_WIN) && last;

`ifdef IFM_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && bus.start) begin
      stall_cnt <= '0;
    end else if ((state == S_WIN) && !bus.win_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifm_buf_ctrl.sv
// Bench: three sequencers (4x4, 5x4, 3x3) with a per-instance window scoreboard and
// directed latency, stall, reset and start-while-busy checks.
module tb_ifm_buf_ctrl;

  localparam logic [2:0] ALL   = 3'b111;
  localparam logic [2:0] RIGHT = 3'b001;
  localparam logic [2:0] DOWN  = 3'b010;
  localparam logic [2:0] LEFT  = 3'b100;
  localparam logic [2:0] KEEP  = 3'b000;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [2:0] cmd;
    logic       last;
  } win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_r = '0;
  logic [2:0] rdy_r = '1;

  logic [2:0] done_w, busy_w, fen_w, wv_w, wl_w;
  logic [2:0] rd_w  [3];
  logic [7:0] row_w [3];
  logic [7:0] col_w [3];
`ifdef IFM_CTRL_PERF_EN
  logic [31:0] sc_w [3];
`endif

  win_t exp_q [3][$];
  int   done_cnt [3];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic win_t w(input int r, input int c, input logic [2:0] cm, input bit l);
    win_t x;
    x.row  = 8'(r);
    x.col  = 8'(c);
    x.cmd  = cm;
    x.last = l;
    return x;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 1) ? 5 : (g == 2) ? 3 : 4;
    localparam int W = (g == 2) ? 3 : 4;

    ifm_buf_ctrl_if #(.DIM_W(8)) bus ();

    assign bus.start     = start_r[g];
    assign bus.win_ready = rdy_r[g];
    assign done_w[g]     = bus.done;
    assign busy_w[g]     = bus.busy;
    assign fen_w[g]      = bus.fetch_en;
    assign wv_w[g]       = bus.win_valid;
    assign wl_w[g]       = bus.win_last;
    assign rd_w[g]       = bus.ifm_read;
    assign row_w[g]      = bus.win_row;
    assign col_w[g]      = bus.win_col;

    ifm_buf_ctrl #(.IFM_H(H), .IFM_W(W), .DIM_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef IFM_CTRL_PERF_EN
      ,
      .stall_cnt (sc_w[g])
`endif
    );

    initial begin : mon
      logic [7:0] fr, fc;
      logic [2:0] lc;
      win_t       e;
      fr = '0; fc = '0; lc = KEEP;
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.fetch_en) begin
            fr = bus.fetch_row;
            fc = bus.fetch_col;
          end
          if (bus.ifm_read != KEEP) lc = bus.ifm_read;
          if (bus.done) done_cnt[g]++;
          if (bus.win_valid && bus.win_ready) begin
            if (exp_q[g].size() == 0) begin
              chk($sformatf("unexpected_window_dut%0d", g), 1, 0);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("win_row_dut%0d", g),   int'(bus.win_row),  int'(e.row));
              chk($sformatf("win_col_dut%0d", g),   int'(bus.win_col),  int'(e.col));
              chk($sformatf("win_last_dut%0d", g),  int'(bus.win_last), int'(e.last));
              chk($sformatf("cmd_dut%0d", g),       int'(lc),           int'(e.cmd));
              chk($sformatf("fetch_row_dut%0d", g), int'(fr),           int'(e.row));
              chk($sformatf("fetch_col_dut%0d", g), int'(fc),           int'(e.col));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on instance g and follows it to done; exp_lat counts cycles from the
  // start-sampling edge to the done cycle.
  task automatic run(input int g, input int exp_lat, input bit poke, input bit stall);
    bit         seen;
    int         st;
    logic [7:0] sr, sc;
    seen = 0; st = 0; sr = '0; sc = '0;
    start_r[g] = 1'b1;
    step();
    start_r[g] = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1) chk("fetch_en_at_k1", int'(fen_w[g]), 1);
      if (i == 2) chk("ifm_read_all_at_k2", int'(rd_w[g]), int'(ALL));
      if (i == 3) chk("win_valid_at_k3", int'(wv_w[g]), 1);
      if (poke) start_r[g] = (i == 5);
      if (stall) begin
        if (st == 0 && wv_w[g] && row_w[g] == 8'd0 && col_w[g] == 8'd1) begin
          st = 1;
          rdy_r[g] = 1'b0;
          sr = row_w[g];
          sc = col_w[g];
        end else if (st >= 1 && st <= 4) begin
          chk("stall_valid", int'(wv_w[g]), 1);
          chk("stall_row", int'(row_w[g]), int'(sr));
          chk("stall_col", int'(col_w[g]), int'(sc));
          chk("stall_keep", int'(rd_w[g]), int'(KEEP));
          st++;
        end else if (st == 5) begin
          rdy_r[g] = 1'b1;
          st = 6;
        end
      end
      if (done_w[g]) begin
        chk($sformatf("done_latency_dut%0d", g), i, exp_lat);
        seen = 1;
        if (poke) start_r[g] = 1'b1;
        break;
      end
      step();
    end
    if (!seen) chk($sformatf("done_timeout_dut%0d", g), 0, 1);
    if (poke) begin
      step();
      start_r[g] = 1'b0;
      chk("busy_after_done_start", int'(busy_w[g]), 0);
      step();
      chk("still_idle", int'(busy_w[g]), 0);
    end
    step();
  endtask

  initial begin
    for (int g = 0; g < 3; g++) done_cnt[g] = 0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    chk("rst_fetch_en", int'(fen_w[0]), 0);
    chk("rst_win_valid", int'(wv_w[0]), 0);
    chk("rst_win_last", int'(wl_w[0]), 0);
    chk("rst_ifm_read", int'(rd_w[0]), int'(KEEP));
    rst = 1'b0;
    step();

    // 4x4 with start poked mid-run and coincident with done
    exp_q[0].push_back(w(0, 0, ALL,   0));
    exp_q[0].push_back(w(0, 1, RIGHT, 0));
    exp_q[0].push_back(w(1, 1, DOWN,  0));
    exp_q[0].push_back(w(1, 0, LEFT,  1));
    run(0, 13, 1, 0);

    exp_q[1].push_back(w(0, 0, ALL,   0));
    exp_q[1].push_back(w(0, 1, RIGHT, 0));
    exp_q[1].push_back(w(1, 1, DOWN,  0));
    exp_q[1].push_back(w(1, 0, LEFT,  0));
    exp_q[1].push_back(w(2, 0, DOWN,  0));
    exp_q[1].push_back(w(2, 1, RIGHT, 1));
    run(1, 19, 0, 0);

    exp_q[2].push_back(w(0, 0, ALL, 1));
    run(2, 4, 0, 0);

    // 4x4 with a 5-cycle stall on window (0,1)
    exp_q[0].push_back(w(0, 0, ALL,   0));
    exp_q[0].push_back(w(0, 1, RIGHT, 0));
    exp_q[0].push_back(w(1, 1, DOWN,  0));
    exp_q[0].push_back(w(1, 0, LEFT,  1));
    run(0, 18, 0, 1);
`ifdef IFM_CTRL_PERF_EN
    chk("stall_cnt", int'(sc_w[0]), 5);
`endif

    // Reset while in LOAD, then a clean restart
    start_r[0] = 1'b1;
    step();
    start_r[0] = 1'b0;
    step();
    chk("load_cmd_before_rst", int'(rd_w[0]), int'(ALL));
    rst = 1'b1;
    step();
    chk("rst_in_load_keep", int'(rd_w[0]), int'(KEEP));
    chk("rst_in_load_busy", int'(busy_w[0]), 0);
    chk("rst_in_load_valid", int'(wv_w[0]), 0);
    rst = 1'b0;
    step();
    exp_q[0].push_back(w(0, 0, ALL,   0));
    exp_q[0].push_back(w(0, 1, RIGHT, 0));
    exp_q[0].push_back(w(1, 1, DOWN,  0));
    exp_q[0].push_back(w(1, 0, LEFT,  1));
    run(0, 13, 0, 0);

    repeat (3) step();
    for (int g = 0; g < 3; g++)
      chk($sformatf("queue_empty_dut%0d", g), exp_q[g].size(), 0);
    chk("done_count_dut0", done_cnt[0], 3);
    chk("done_count_dut1", done_cnt[1], 1);
    chk("done_count_dut2", done_cnt[2], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifm_buf_ctrl.md
Name: ifm_buf_ctrl

Overview:
- Sequencer for the 3x3 IFM window buffer. Walks a 3x3 window over an IFM_H x IFM_W input feature map in snake order: left-to-right on even window rows, right-to-left on odd window rows.
- Issues one fetch request per window to IFM memory, then the matching ifm_read command (ALL/RIGHT/DOWN/LEFT/KEEP) to the buffer.
- Presents each loaded window to the PE array under a valid/ready handshake.
- Sits between the top-level layer control, IFM memory and the window buffer.

Parameters:
- IFM_H, 8, IFM rows; must be >= 3.
- IFM_W, 8, IFM columns; must be >= 3.
- DIM_W, 8, width of row/column coordinates; must hold max(IFM_H, IFM_W).
- ALL / RIGHT / DOWN / LEFT / KEEP, 3'b111 / 3'b001 / 3'b010 / 3'b100 / 3'b000, buffer command encodings.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  pulse; begin traversal. Ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.
- fetch_en  out  1  IFM memory read strobe. Memory returns data one cycle later.
- fetch_row  out  DIM_W  top row of the new window.
- fetch_col  out  DIM_W  left column of the new window.
- ifm_read  out  3  buffer command.
- win_valid  out  1  buffer outputs hold a complete window.
- win_ready  in  1  PE array accepts the window.
- win_row  out  DIM_W  window top-left row.
- win_col  out  DIM_W  window top-left column.
- win_last  out  1  qualifies win_valid; marks the final window.

Behaviour:
- Fetch addressing:
  - Memory word k carries row fetch_row+k, packed as cols fetch_col, +1, +2 in bits [23:16], [15:8], [7:0].
  - fetch_row/fetch_col always equal the top-left of the window being loaded, so RIGHT/LEFT/DOWN read the correct byte lane.
- Internal registers: r, c (DIM_W each), dir_right (1), cmd (3), state.
- States: IDLE, FETCH, LOAD, WIN, DONE.
- IDLE:
  - Outputs at default: ifm_read=KEEP, all strobes 0.
  - On start: r=0, c=0, dir_right=1, cmd=ALL, go to FETCH.
- FETCH: fetch_en=1, fetch_row=r, fetch_col=c; go to LOAD.
- LOAD: ifm_read=cmd, for exactly one cycle; go to WIN.
- WIN:
  - win_valid=1, win_row=r, win_col=c, ifm_read=KEEP.
  - win_last = (r==IFM_H-3) && (dir_right ? c==IFM_W-3 : c==0).
  - On win_valid&&win_ready with win_last: go to DONE.
  - Otherwise on handshake, select next move and go to FETCH:
    - dir_right && c<IFM_W-3: cmd=RIGHT, c+1.
    - !dir_right && c>0: cmd=LEFT, c-1.
    - else: cmd=DOWN, r+1, toggle dir_right.
  - win_ready low: stay in WIN, all outputs stable, buffer held by KEEP.
- DONE: done=1 for one cycle; go to IDLE.
- Latency:
  - start sampled at edge k → fetch_en in cycle k+1, ifm_read=ALL in k+2, win_valid in k+3.
  - With win_ready tied high: 3 cycles per window, (IFM_H-2)*(IFM_W-2) windows, done one cycle after the last handshake.
- Reset values: state=IDLE, r=c=0, dir_right=1, cmd=KEEP. All outputs 0, except ifm_read=KEEP (3'b000).
- Boundaries:
  - IFM_W==3: only DOWN moves.
  - IFM_H==3: single pass, no DOWN.
  - 3x3 IFM: one window (ALL), win_last on the first window.
  - start while busy: ignored.
  - start in the same cycle as done: ignored; it is sampled only in IDLE.
  - rst at any point: returns to IDLE at the next edge. ifm_read=KEEP from that edge on; no partial command is issued.
  - ifm_read is never an encoding outside the five listed, so the buffer's default (clear) branch is never hit.

Optional Feature:
- Macro IFM_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt[31:0]: counts cycles in WIN with win_ready low.
  - Cleared by rst and on start accepted; saturates at 32'hFFFFFFFF; held after done.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- IFM 4x4, win_ready=1, start pulse → ifm_read sequence ALL, RIGHT, DOWN, LEFT. Windows (0,0),(0,1),(1,1),(1,0); win_last on (1,0); done 13 cycles after start.
- IFM 5x4 → windows (0,0),(0,1),(1,1),(1,0),(2,0),(2,1); cmds ALL, R, D, L, D, R. fetch_row/fetch_col match each window.
- IFM 3x3 → single ALL fetch at (0,0), win_last=1 on the first window, done next cycle after the handshake.
- win_ready held low for 5 cycles on window (0,1) → win_valid, win_row/win_col and ifm_read=KEEP stable throughout. With IFM_CTRL_PERF_EN, stall_cnt=5.
- rst asserted while in LOAD → next cycle state IDLE, ifm_read=KEEP, busy=0. A subsequent start restarts from ALL at (0,0).
- start pulsed again while busy (and coincident with done) → no effect; traversal count unchanged.
